// File: rtl/carregador_matriz_pkg.sv
// Shared constants and state encoding for the matrix loader and the scalar-matrix multiplier.
package pacote_matriz;

  localparam int unsigned N        = 5;
  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned NUM_ELEM = N * N;
  localparam int unsigned MAT_W    = N * N * ELEM_W;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic {
    LOAD   = 1'b0,
    SCALAR = 1'b1
  } estado_t;

endpackage

// File: rtl/carregador_matriz.sv
// Serial byte loader feeding multiplicacao_num_matriz.
// Collects N*N signed elements (row-major) into a shadow buffer, then one scalar
// beat commits buffer + scalar to the registered operand outputs.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   in_valid/in_ready  - input beat handshake (in_ready is combinational)
//   in_data            - element or scalar beat
//   matriz_A           - committed matrix, element (i,j) at [(i*N+j)*ELEM_W +: ELEM_W]
//   num_inteiro        - committed scalar
//   out_valid/out_ready- operand-set handshake
//   elem_count         - elements held in the shadow buffer (0..N*N)
module carregador_matriz #(
  parameter int unsigned N      = pacote_matriz::N,
  parameter int unsigned ELEM_W = pacote_matriz::ELEM_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ELEM_W-1:0]          in_data,
  output logic [N*N*ELEM_W-1:0]      matriz_A,
  output logic [ELEM_W-1:0]          num_inteiro,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [pacote_matriz::CNT_W-1:0] elem_count
);

  localparam int unsigned MAT_W  = N * N * ELEM_W;
  localparam int unsigned CNT_W  = pacote_matriz::CNT_W;
  localparam int unsigned SLOT_W = $clog2(MAT_W);

  pacote_matriz::estado_t state_q, state_d;
  logic [CNT_W-1:0]  count_d;
  logic [MAT_W-1:0]  shadow_q;
  logic [SLOT_W-1:0] slot_base;
  logic              accept;
  logic              wr_slot;
  logic              commit;

  // Scalar beat may only land when the held set is free or leaving this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (state_q == pacote_matriz::LOAD) in_ready = 1'b1;
      else                                in_ready = !out_valid || out_ready;
    end
  end

  assign accept    = in_valid && in_ready;
  assign slot_base = SLOT_W'(elem_count) * SLOT_W'(ELEM_W);

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    count_d = elem_count;
    wr_slot = 1'b0;
    commit  = 1'b0;
    case (state_q)
      pacote_matriz::LOAD: begin
        if (accept) begin
          wr_slot = 1'b1;
          count_d = elem_count + CNT_W'(1);
          if (elem_count == CNT_W'(N * N - 1)) state_d = pacote_matriz::SCALAR;
        end
      end
      pacote_matriz::SCALAR: begin
        if (accept) begin
          commit  = 1'b1;
          count_d = '0;
          state_d = pacote_matriz::LOAD;
        end
      end
    endcase
  end

  // State, shadow buffer and registered operand outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= pacote_matriz::LOAD;
      elem_count  <= '0;
      shadow_q    <= '0;
      matriz_A    <= '0;
      num_inteiro <= '0;
      out_valid   <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_count <= count_d;
      if (wr_slot) shadow_q[slot_base +: ELEM_W] <= in_data;
      if (commit) begin
        matriz_A    <= shadow_q;
        num_inteiro <= in_data;
        out_valid   <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_carregador_matriz.sv
// Directed bench for carregador_matriz: table of full loads plus hand sequences
// for back-pressure, input gaps, mid-load reset and a continuous stream.
module tb_carregador_matriz;
  import pacote_matriz::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;
  logic [MAT_W-1:0]  matriz_A;
  logic [ELEM_W-1:0] num_inteiro;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  elem_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]       cur [NUM_ELEM];
  logic [7:0]       stream [3*(NUM_ELEM+1)];
  logic [MAT_W-1:0] mat_a_exp;

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] scalar;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  carregador_matriz dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .matriz_A    (matriz_A),
    .num_inteiro (num_inteiro),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .elem_count  (elem_count)
  );

  task automatic chk(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat; returns one cycle after it is accepted (edge + 1).
  task automatic send(input logic [7:0] d);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && w < 200) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (w >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout act=not_ready exp=ready");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_cur();
    for (int k = 0; k < int'(NUM_ELEM); k++) send(cur[k]);
  endtask

  function automatic logic [MAT_W-1:0] model_mat();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int k = 0; k < int'(NUM_ELEM); k++) m[k*ELEM_W +: ELEM_W] = cur[k];
    return m;
  endfunction

  task automatic fill_cur(input logic [7:0] base, input logic [7:0] step);
    for (int k = 0; k < int'(NUM_ELEM); k++) cur[k] = 8'(base + 8'(k) * step);
  endtask

  initial begin
    int t0;
    int pulse_c [$];
    int p;
    logic [MAT_W-1:0] exp_m;

    vecs[0] = '{8'h01, 8'h01, 8'h02, 8'h01, 8'h19};
    vecs[1] = '{8'h0A, 8'h00, 8'h05, 8'h0A, 8'h0A};
    vecs[2] = '{8'hF4, 8'h01, 8'hFF, 8'hF4, 8'h0C};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("in_ready_in_reset", MAT_W'(in_ready), MAT_W'(1'b0));
    tick(); tick();
    chk("rst_out_valid", MAT_W'(out_valid), '0);
    chk("rst_elem_count", MAT_W'(elem_count), '0);
    chk("rst_matriz", matriz_A, '0);
    chk("rst_num", MAT_W'(num_inteiro), '0);
    rst = 1'b0;
    #1;
    chk("in_ready_load", MAT_W'(in_ready), MAT_W'(1'b1));
    tick();

    // Table-driven full loads with consumer always ready.
    for (int v = 0; v < 3; v++) begin
      fill_cur(vecs[v].base, vecs[v].step);
      send_cur();
      chk($sformatf("v%0d_count25", v), MAT_W'(elem_count), MAT_W'(25));
      chk($sformatf("v%0d_valid_pre", v), MAT_W'(out_valid), '0);
      send(vecs[v].scalar);
      chk($sformatf("v%0d_valid", v), MAT_W'(out_valid), MAT_W'(1'b1));
      chk($sformatf("v%0d_first", v), MAT_W'(matriz_A[7:0]), MAT_W'(vecs[v].exp_first));
      chk($sformatf("v%0d_last", v), MAT_W'(matriz_A[MAT_W-1 -: 8]), MAT_W'(vecs[v].exp_last));
      chk($sformatf("v%0d_num", v), MAT_W'(num_inteiro), MAT_W'(vecs[v].scalar));
      chk($sformatf("v%0d_full", v), matriz_A, model_mat());
      chk($sformatf("v%0d_count0", v), MAT_W'(elem_count), '0);
      tick();
      chk($sformatf("v%0d_consumed", v), MAT_W'(out_valid), '0);
    end

    // Extreme signed values stored verbatim.
    for (int k = 0; k < int'(NUM_ELEM); k++) cur[k] = 8'h00;
    cur[0] = 8'h80; cur[1] = 8'hFF; cur[2] = 8'h7F;
    send_cur();
    send(8'hFD);
    chk("ext_b0", MAT_W'(matriz_A[7:0]), MAT_W'(8'h80));
    chk("ext_b1", MAT_W'(matriz_A[15:8]), MAT_W'(8'hFF));
    chk("ext_b2", MAT_W'(matriz_A[23:16]), MAT_W'(8'h7F));
    chk("ext_num", MAT_W'(num_inteiro), MAT_W'(8'hFD));
    chk("ext_full", matriz_A, model_mat());
    tick();

    // Back-pressure: second matrix loads while the first is held.
    out_ready = 1'b0;
    fill_cur(8'h01, 8'h01);
    mat_a_exp = model_mat();
    send_cur();
    send(8'h02);
    chk("bp_first_valid", MAT_W'(out_valid), MAT_W'(1'b1));
    fill_cur(8'h0A, 8'h00);
    send_cur();
    chk("bp_count25", MAT_W'(elem_count), MAT_W'(25));
    in_valid = 1'b1; in_data = 8'h05;
    #1;
    chk("bp_in_ready_low", MAT_W'(in_ready), '0);
    tick(); tick(); tick();
    chk("bp_hold_ready", MAT_W'(in_ready), '0);
    chk("bp_hold_valid", MAT_W'(out_valid), MAT_W'(1'b1));
    chk("bp_hold_mat", matriz_A, mat_a_exp);
    chk("bp_hold_num", MAT_W'(num_inteiro), MAT_W'(8'h02));
    chk("bp_hold_count", MAT_W'(elem_count), MAT_W'(25));
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", MAT_W'(in_ready), MAT_W'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_swap_valid", MAT_W'(out_valid), MAT_W'(1'b1));
    chk("bp_swap_mat", matriz_A, model_mat());
    chk("bp_swap_num", MAT_W'(num_inteiro), MAT_W'(8'h05));
    chk("bp_swap_count", MAT_W'(elem_count), '0);
    tick();
    chk("bp_consumed", MAT_W'(out_valid), '0);

    // in_valid toggled every other cycle.
    fill_cur(8'h30, 8'h03);
    t0 = int'($time);
    for (int k = 0; k <= int'(NUM_ELEM); k++) begin
      tick();
      if (k == 5) chk("gap_count_hold", MAT_W'(elem_count), MAT_W'(5));
      send(k < int'(NUM_ELEM) ? cur[k] : 8'h09);
    end
    chk("gap_cycles", MAT_W'((int'($time) - t0) / 10), MAT_W'(52));
    chk("gap_valid", MAT_W'(out_valid), MAT_W'(1'b1));
    chk("gap_mat", matriz_A, model_mat());
    chk("gap_num", MAT_W'(num_inteiro), MAT_W'(8'h09));
    tick();

    // Reset mid-load with a held operand set discards everything.
    out_ready = 1'b0;
    fill_cur(8'h01, 8'h01);
    send_cur();
    send(8'h02);
    for (int k = 0; k < 10; k++) send(8'h0A);
    chk("mid_count10", MAT_W'(elem_count), MAT_W'(10));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", MAT_W'(elem_count), '0);
    chk("mid_rst_valid", MAT_W'(out_valid), '0);
    chk("mid_rst_mat", matriz_A, '0);
    out_ready = 1'b1;
    fill_cur(8'h00, 8'h03);
    send_cur();
    send(8'h07);
    chk("mid_new_valid", MAT_W'(out_valid), MAT_W'(1'b1));
    chk("mid_new_mat", matriz_A, model_mat());
    chk("mid_new_num", MAT_W'(num_inteiro), MAT_W'(8'h07));
    tick();

    // Continuous stream of three operand sets, one beat per cycle.
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < int'(NUM_ELEM); k++) stream[m*26 + k] = 8'(m * 40 + k + 1);
      stream[m*26 + 25] = 8'(m + 1);
    end
    p = 0;
    for (int c = 0; c < 80; c++) begin
      in_valid = (c < 78);
      in_data  = (c < 78) ? stream[c] : 8'h00;
      @(posedge clk); #1;
      if (out_valid) begin
        pulse_c.push_back(c);
        if (p < 3) begin
          for (int k = 0; k < int'(NUM_ELEM); k++) cur[k] = stream[p*26 + k];
          exp_m = model_mat();
          chk($sformatf("str%0d_mat", p), matriz_A, exp_m);
          chk($sformatf("str%0d_num", p), MAT_W'(num_inteiro), MAT_W'(stream[p*26 + 25]));
        end
        p++;
      end
    end
    in_valid = 1'b0;
    chk("str_pulses", MAT_W'(pulse_c.size()), MAT_W'(3));
    if (pulse_c.size() == 3) begin
      chk("str_first_at", MAT_W'(pulse_c[0]), MAT_W'(25));
      chk("str_gap1", MAT_W'(pulse_c[1] - pulse_c[0]), MAT_W'(26));
      chk("str_gap2", MAT_W'(pulse_c[2] - pulse_c[1]), MAT_W'(26));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
